// File: rtl/td4x_pkg.sv
// Shared definitions for the TD4X accumulator CPU: opcode map, ALU source
// select, register load-vector bit positions and fetch/execute state encoding.
package td4x_pkg;

    // Opcode map (upper nibble of each instruction word)
    localparam logic [3:0] OP_ADD_A  = 4'b0000;  // A   <= A + imm
    localparam logic [3:0] OP_MOV_AB = 4'b0001;  // A   <= B + imm
    localparam logic [3:0] OP_IN_A   = 4'b0010;  // A   <= IN + imm
    localparam logic [3:0] OP_MOV_AI = 4'b0011;  // A   <= imm
    localparam logic [3:0] OP_MOV_BA = 4'b0100;  // B   <= A + imm
    localparam logic [3:0] OP_ADD_B  = 4'b0101;  // B   <= B + imm
    localparam logic [3:0] OP_IN_B   = 4'b0110;  // B   <= IN + imm
    localparam logic [3:0] OP_MOV_BI = 4'b0111;  // B   <= imm
    localparam logic [3:0] OP_OUT_B  = 4'b1001;  // OUT <= B + imm
    localparam logic [3:0] OP_OUT_I  = 4'b1011;  // OUT <= imm
    localparam logic [3:0] OP_HALT   = 4'b1101;  // stop fetching
    localparam logic [3:0] OP_JNC    = 4'b1110;  // PC <= imm when carry clear
    localparam logic [3:0] OP_JMP    = 4'b1111;  // PC <= imm

    // ALU source operand select
    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_IN   = 2'd2,
        SEL_ZERO = 2'd3
    } sel_e;

    // Bit positions inside the register load vector
    localparam int LD_A   = 0;
    localparam int LD_B   = 1;
    localparam int LD_OUT = 2;
    localparam int LD_PC  = 3;
    localparam int LD_W   = 4;

    // Core sequencing states
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // One-hot load vector with only bit idx set
    function automatic logic [LD_W-1:0] ld_mask(input int unsigned idx);
        return LD_W'(1) << idx;
    endfunction

endpackage

// File: rtl/td4x_cpu_core_decoder.sv
// Instruction decoder: maps {opcode, carry} onto ALU source select, register
// load vector and halt request. Unlisted opcodes decode as NOP (no loads,
// zero source so the carry result is 0).
module td4x_decoder
    import td4x_pkg::*;
(
    input  logic [3:0]      opcode,
    input  logic            carry,
    output sel_e            sel,
    output logic [LD_W-1:0] load,
    output logic            halt
);

    // Pure lookup; every output defaulted so illegal opcodes fall through to NOP
    always_comb begin
        sel  = SEL_ZERO;
        load = '0;
        halt = 1'b0;
        case (opcode)
            OP_ADD_A: begin
                sel  = SEL_A;
                load = ld_mask(LD_A);
            end
            OP_MOV_AB: begin
                sel  = SEL_B;
                load = ld_mask(LD_A);
            end
            OP_IN_A: begin
                sel  = SEL_IN;
                load = ld_mask(LD_A);
            end
            OP_MOV_AI: begin
                sel  = SEL_ZERO;
                load = ld_mask(LD_A);
            end
            OP_MOV_BA: begin
                sel  = SEL_A;
                load = ld_mask(LD_B);
            end
            OP_ADD_B: begin
                sel  = SEL_B;
                load = ld_mask(LD_B);
            end
            OP_IN_B: begin
                sel  = SEL_IN;
                load = ld_mask(LD_B);
            end
            OP_MOV_BI: begin
                sel  = SEL_ZERO;
                load = ld_mask(LD_B);
            end
            OP_OUT_B: begin
                sel  = SEL_B;
                load = ld_mask(LD_OUT);
            end
            OP_OUT_I: begin
                sel  = SEL_ZERO;
                load = ld_mask(LD_OUT);
            end
            OP_JMP: begin
                sel  = SEL_ZERO;
                load = ld_mask(LD_PC);
            end
            OP_JNC: begin
                // Jump only when the previous instruction left carry clear
                sel  = SEL_ZERO;
                load = carry ? '0 : ld_mask(LD_PC);
            end
            OP_HALT: begin
                sel  = SEL_ZERO;
                halt = 1'b1;
            end
            default: begin
                sel  = SEL_ZERO;
                load = '0;
            end
        endcase
    end

endmodule

// File: rtl/td4x_cpu_core.sv
// TD4X add-immediate accumulator CPU core with req/ack instruction fetch.
// Two-phase sequencing (FETCH then EXEC), HALT parks the core until reset.
// Optional macro TD4X_IN_SYNC_EN: in_port passes a 2-flop synchroniser
// before the IN register; otherwise a single register stage is used.
module td4x_cpu_core
    import td4x_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [DATA_W+3:0]   imem_data,
    input  logic [DATA_W-1:0]   in_port,
    output logic [DATA_W-1:0]   out_port,
    output logic                carry,
    output logic                halted
);

`ifdef TD4X_IN_SYNC_EN
    localparam int IN_STAGES = 2;
`else
    localparam int IN_STAGES = 1;
`endif

    // Architectural and sequencing state
    state_e              state_q,  state_d;
    logic                req_q,    req_d;
    logic [DATA_W+3:0]   ir_q,     ir_d;
    logic [DATA_W-1:0]   a_q,      a_d;
    logic [DATA_W-1:0]   b_q,      b_d;
    logic [DATA_W-1:0]   out_q,    out_d;
    logic [ADDR_W-1:0]   pc_q,     pc_d;
    logic                carry_q,  carry_d;
    logic                halted_q, halted_d;

    // Input capture chain; the last stage is the IN register seen by EXEC
    logic [DATA_W-1:0]   in_stage_q [IN_STAGES];
    logic [DATA_W-1:0]   in_stage_d [IN_STAGES];
    logic [DATA_W-1:0]   in_val;

    // Decode / ALU
    logic [3:0]          opcode;
    logic [DATA_W-1:0]   imm;
    sel_e                dec_sel;
    logic [LD_W-1:0]     dec_load;
    logic                dec_halt;
    logic [DATA_W-1:0]   alu_src;
    logic [DATA_W:0]     alu_sum;
    logic [ADDR_W-1:0]   jmp_target;
    logic [ADDR_W-1:0]   pc_inc;

    generate
        for (genvar gi = 0; gi < IN_STAGES; gi++) begin : g_in_stage
            if (gi == 0) begin : g_head
                assign in_stage_d[gi] = in_port;
            end else begin : g_tail
                assign in_stage_d[gi] = in_stage_q[gi-1];
            end

            // Sample every clock regardless of core state
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_stage_q[gi] <= '0;
                end else begin
                    in_stage_q[gi] <= in_stage_d[gi];
                end
            end
        end
    endgenerate

    assign in_val = in_stage_q[IN_STAGES-1];

    assign opcode = ir_q[DATA_W+3:DATA_W];
    assign imm    = ir_q[DATA_W-1:0];

    td4x_decoder u_decoder (
        .opcode (opcode),
        .carry  (carry_q),
        .sel    (dec_sel),
        .load   (dec_load),
        .halt   (dec_halt)
    );

    // ALU operand mux: selected source, or zero for immediate-only ops
    always_comb begin
        alu_src = '0;
        case (dec_sel)
            SEL_A:   alu_src = a_q;
            SEL_B:   alu_src = b_q;
            SEL_IN:  alu_src = in_val;
            default: alu_src = '0;
        endcase
    end

    // One extra bit keeps the carry-out; the data part wraps naturally
    assign alu_sum = {1'b0, alu_src} + {1'b0, imm};

    // Size cast zero-extends a narrow immediate or keeps its low ADDR_W bits
    assign jmp_target = ADDR_W'(imm);
    assign pc_inc     = pc_q + ADDR_W'(1);

    // Next-state: fetch handshake, single-cycle execute, absorbing halt
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        pc_d     = pc_q;
        carry_d  = carry_q;
        halted_d = halted_q;

        case (state_q)
            ST_FETCH: begin
                // req_q is low only in the first cycle out of reset, so an
                // ack there is ignored; afterwards req holds until ack
                if (req_q && imem_ack) begin
                    ir_d    = imem_data;
                    req_d   = 1'b0;
                    state_d = ST_EXEC;
                end else begin
                    req_d   = 1'b1;
                end
            end

            ST_EXEC: begin
                carry_d = alu_sum[DATA_W];
                if (dec_load[LD_A])   a_d   = alu_sum[DATA_W-1:0];
                if (dec_load[LD_B])   b_d   = alu_sum[DATA_W-1:0];
                if (dec_load[LD_OUT]) out_d = alu_sum[DATA_W-1:0];

                if (dec_halt) begin
                    halted_d = 1'b1;
                    req_d    = 1'b0;
                    state_d  = ST_HALTED;
                end else begin
                    pc_d     = dec_load[LD_PC] ? jmp_target : pc_inc;
                    req_d    = 1'b1;
                    state_d  = ST_FETCH;
                end
            end

            ST_HALTED: begin
                req_d = 1'b0;
            end

            default: begin
                state_d = ST_FETCH;
                req_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset takes effect immediately, no fetch retry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            req_q    <= 1'b0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            pc_q     <= '0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            pc_q     <= pc_d;
            carry_q  <= carry_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign out_port  = out_q;
    assign carry     = carry_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_td4x_cpu_core.sv
// Testbench for td4x_cpu_core: instruction-level reference model with a
// per-cycle compare process, plus directed programs with literal expectations.
module tb_td4x_cpu_core;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int IW = DW + 4;
`ifdef TD4X_IN_SYNC_EN
    localparam int          IN_LAT = 2;
    localparam logic [DW-1:0] EXP_IN = 4'h5;
`else
    localparam int          IN_LAT = 1;
    localparam logic [DW-1:0] EXP_IN = 4'hA;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ack = 1'b0;
    logic [IW-1:0]  mem_data = '0;
    logic [DW-1:0]  in_port = '0;
    logic           imem_req;
    logic [AW-1:0]  imem_addr;
    logic [DW-1:0]  out_port;
    logic           carry;
    logic           halted;

    // Wide-PC instance: always-ack memory, JMP 0xF at 0, HALT elsewhere
    logic           req6;
    logic [5:0]     addr6;
    logic [7:0]     data6;
    logic [3:0]     in6 = 4'h0;
    logic [3:0]     out6;
    logic           carry6;
    logic           halted6;

    td4x_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (ack),
        .imem_data (mem_data),
        .in_port   (in_port),
        .out_port  (out_port),
        .carry     (carry),
        .halted    (halted)
    );

    td4x_cpu_core #(.DATA_W(4), .ADDR_W(6)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (req6),
        .imem_addr (addr6),
        .imem_ack  (req6),
        .imem_data (data6),
        .in_port   (in6),
        .out_port  (out6),
        .carry     (carry6),
        .halted    (halted6)
    );

    assign data6 = (addr6 == 6'h00) ? 8'hFF : 8'hD0;

    always #5 clk = ~clk;

    // Program memory and memory-responder configuration (written by main)
    logic [IW-1:0]  prog [16];
    int             wait_cfg = 0;
    logic           spur_en  = 1'b0;

    // Fetch log (written by responder only)
    logic [AW-1:0]  trace [$];
    int             ackc  [$];
    int             cyc  = 0;
    int             wcnt = 0;
    logic [5:0]     q6 [$];

    // Memory responder: wait_cfg idle cycles, then ack with the program word.
    // With spur_en it also raises ack (junk data) while no request is pending.
    always @(negedge clk) begin
        cyc++;
        if (!rst && imem_req) begin
            if (wcnt >= wait_cfg) begin
                ack      = 1'b1;
                mem_data = prog[imem_addr];
                wcnt     = 0;
                trace.push_back(imem_addr);
                ackc.push_back(cyc);
                $display("fetch #%0d addr=%h instr=%h cyc=%0d", trace.size(), imem_addr, prog[imem_addr], cyc);
            end else begin
                ack      = 1'b0;
                mem_data = IW'($urandom);
                wcnt++;
            end
        end else begin
            ack      = spur_en;
            mem_data = 8'hB5;
            wcnt     = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && req6 && q6.size() < 4) q6.push_back(addr6);
    end

    // Reference model: architectural state plus "waiting for ack" / "instruction
    // in hand" phases, advanced on each rising edge from the ISA table.
    logic [DW-1:0]  m_a, m_b, m_out, m_in1, m_in2;
    logic [AW-1:0]  m_pc;
    logic           m_c, m_halt, m_req, m_exec;
    logic [IW-1:0]  m_ir;

    function automatic logic [DW:0] addc(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [DW-1:0] na, nb, no, imm, src;
        logic [AW-1:0] npc;
        logic          nc, nh, nreq, nexec;
        logic [IW-1:0] nir;
        if (rst) begin
            m_a <= '0; m_b <= '0; m_out <= '0; m_pc <= '0; m_c <= 1'b0;
            m_halt <= 1'b0; m_req <= 1'b0; m_exec <= 1'b0; m_ir <= '0;
            m_in1 <= '0; m_in2 <= '0;
        end else begin
            na = m_a; nb = m_b; no = m_out; npc = m_pc; nc = m_c; nh = m_halt;
            nreq = m_req; nexec = m_exec; nir = m_ir;
            src = (IN_LAT == 2) ? m_in2 : m_in1;
            if (m_halt) begin
                nreq = 1'b0;
            end else if (m_exec) begin
                imm = m_ir[DW-1:0];
                nc  = 1'b0;
                npc = m_pc + AW'(1);
                case (m_ir[IW-1:DW])
                    4'h0: {nc, na} = addc(m_a, imm);
                    4'h1: {nc, na} = addc(m_b, imm);
                    4'h2: {nc, na} = addc(src, imm);
                    4'h3: na = imm;
                    4'h4: {nc, nb} = addc(m_a, imm);
                    4'h5: {nc, nb} = addc(m_b, imm);
                    4'h6: {nc, nb} = addc(src, imm);
                    4'h7: nb = imm;
                    4'h9: {nc, no} = addc(m_b, imm);
                    4'hB: no = imm;
                    4'hF: npc = AW'(imm);
                    4'hE: if (!m_c) npc = AW'(imm);
                    4'hD: begin nh = 1'b1; npc = m_pc; end
                    default: ;
                endcase
                nexec = 1'b0;
                nreq  = !nh;
            end else if (m_req && ack) begin
                nir   = mem_data;
                nexec = 1'b1;
                nreq  = 1'b0;
            end else begin
                nreq  = 1'b1;
            end
            m_a <= na; m_b <= nb; m_out <= no; m_pc <= npc; m_c <= nc; m_halt <= nh;
            m_req <= nreq; m_exec <= nexec; m_ir <= nir;
            m_in2 <= m_in1;
            m_in1 <= in_port;
        end
    end

    // Literal expectations posted by the main sequence, drained by the checker
    string          lit_nm  [128];
    logic [31:0]    lit_act [128];
    logic [31:0]    lit_exp [128];
    int             lit_wr = 0;
    int             lit_rd = 0;

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_nm[lit_wr]  = nm;
        lit_act[lit_wr] = act;
        lit_exp[lit_wr] = exp;
        lit_wr++;
    endtask

    // Checker: the only process touching total/bad
    int total = 0;
    int bad   = 0;
    int carry_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("req", 32'(imem_req), 32'(m_req));
            if (m_req) chk("addr", 32'(imem_addr), 32'(m_pc));
            chk("out_port", 32'(out_port), 32'(m_out));
            chk("carry", 32'(carry), 32'(m_c));
            chk("halted", 32'(halted), 32'(m_halt));
            if (carry) carry_cnt++;
        end
        while (lit_rd < lit_wr) begin
            chk(lit_nm[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
    end

    task automatic load_nops();
        for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    endtask

    task automatic wait_halt(input int lim, input string nm);
        int i;
        i = 0;
        while (!halted && i < lim) begin
            @(negedge clk);
            i++;
        end
        if (!halted) post({nm, "_halt_timeout"}, 32'(halted), 1);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0, c0, cnt, i;

        // ---- A: carry from ADD, JNC not taken, zero-wait throughput ----
        load_nops();
        prog[0] = 8'h3F;  // MOV A,F
        prog[1] = 8'h01;  // ADD A,1   -> A=0, carry=1
        prog[2] = 8'hE5;  // JNC 5     -> not taken
        prog[3] = 8'h40;  // MOV B,A   -> B=0
        prog[4] = 8'h93;  // OUT B,+3  -> OUT=3
        prog[5] = 8'hD0;  // HALT
        wait_cfg = 0;
        spur_en  = 1'b1;
        t0 = trace.size();
        c0 = carry_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_halt(100, "A");
        @(negedge clk);
        post("A_halted", 32'(halted), 1);
        post("A_out", 32'(out_port), 3);
        post("A_carry_end", 32'(carry), 0);
        post("A_carry_seen", 32'(carry_cnt > c0), 1);
        post("A_nfetch", 32'(trace.size() - t0), 6);
        for (int k = 0; k < 6; k++)
            if (trace.size() > t0 + k) post("A_fetch_addr", 32'(trace[t0+k]), 32'(k));
        for (int k = 1; k < 6; k++)
            if (ackc.size() > t0 + k) post("A_ack_gap", 32'(ackc[t0+k] - ackc[t0+k-1]), 2);
        post("W6_nfetch", 32'(q6.size() >= 2), 1);
        post("W6_jmp_target", (q6.size() >= 2) ? 32'(q6[1]) : 32'hFFFF, 32'h0F);
        post("W6_halted", 32'(halted6), 1);

        // ---- B: wait-stated fetch, then asynchronous reset mid-fetch ----
        enter_reset();
        load_nops();
        prog[0] = 8'h3C;  // MOV A,C
        prog[1] = 8'h40;  // MOV B,A
        prog[2] = 8'h91;  // OUT B,+1 -> D
        prog[3] = 8'h05;  // ADD A,5  -> carry=1
        prog[4] = 8'hF0;  // JMP 0
        wait_cfg = 3;
        spur_en  = 1'b0;
        t0 = trace.size();
        rst = 1'b0;
        i = 0;
        while (!(carry && imem_req && out_port == 4'hD) && i < 200) begin
            @(negedge clk);
            i++;
        end
        post("B_reached", 32'(carry && imem_req && out_port == 4'hD), 1);
        post("B_addr_held", 32'(imem_addr), 4);
        for (int k = 1; k < 4; k++)
            if (ackc.size() > t0 + k) post("B_ack_gap", 32'(ackc[t0+k] - ackc[t0+k-1]), 5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        post("R_req", 32'(imem_req), 0);
        post("R_addr", 32'(imem_addr), 0);
        post("R_out", 32'(out_port), 0);
        post("R_carry", 32'(carry), 0);
        post("R_halted", 32'(halted), 0);
        repeat (2) @(negedge clk);

        // ---- C: IN latency, IN A / MOV B,A / OUT B ----
        load_nops();
        prog[0] = 8'h20;  // IN A
        prog[1] = 8'h40;  // MOV B,A
        prog[2] = 8'h90;  // OUT B
        prog[3] = 8'hD0;  // HALT
        wait_cfg = 0;
        in_port  = 4'h5;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_port = 4'hA;   // changes one edge before IN is fetched
        wait_halt(100, "C");
        @(negedge clk);
        post("C_in_latency", 32'(out_port), 32'(EXP_IN));

        // ---- D: PC wrap from 0xF to 0x0 ----
        enter_reset();
        load_nops();
        prog[0] = 8'hFF;  // JMP F
        t0 = trace.size();
        rst = 1'b0;
        repeat (14) @(negedge clk);
        post("D_nfetch", 32'(trace.size() - t0 >= 4), 1);
        post("D_jump", (trace.size() > t0 + 1) ? 32'(trace[t0+1]) : 32'hFFFF, 32'hF);
        post("D_wrap", (trace.size() > t0 + 2) ? 32'(trace[t0+2]) : 32'hFFFF, 32'h0);

        // ---- E: HALT at 0x3 is absorbing ----
        enter_reset();
        load_nops();
        prog[0] = 8'hB9;  // OUT 9
        prog[3] = 8'hD0;  // HALT
        prog[4] = 8'hB1;  // OUT 1 (must never run)
        spur_en = 1'b1;
        t0 = trace.size();
        rst = 1'b0;
        wait_halt(100, "E");
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (imem_req) cnt++;
        end
        post("E_req_while_halted", 32'(cnt), 0);
        post("E_out", 32'(out_port), 9);
        post("E_halted", 32'(halted), 1);
        post("E_nfetch", 32'(trace.size() - t0), 4);
        post("E_last_addr", (trace.size() > t0) ? 32'(trace[trace.size()-1]) : 32'hFFFF, 3);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
